// File: rtl/mem_port_arb.sv
// Arbitrates one shared single-outstanding memory port between instruction fetch and load/store.
// Load/store has priority, but fetch is forced through after STARVE_MAX consecutive load/store wins.
module mem_port_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IF_WAIT,
    S_LS_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_starve_cnt;
  logic            r_err;
  logic            w_starved;
  logic            w_if_win;
  logic            w_ls_win;

  assign w_starved = (r_starve_cnt == CW'(STARVE_MAX));
  assign w_if_win  = if_req & (~ls_req | w_starved);
  assign w_ls_win  = ls_req & ~w_if_win;
  assign err       = r_err;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (if_gnt)      w_next_state = S_IF_WAIT;
        else if (ls_gnt) w_next_state = S_LS_WAIT;
      end
      S_IF_WAIT, S_LS_WAIT: begin
        if (mem_rvalid) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = 32'h0;
    ls_rdata  = 32'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    busy      = 1'b0;
    // Reset forces every handshake quiet, even while a transaction is being abandoned.
    if (!rst_n) begin
      unique case (r_state)
        S_IDLE: begin
          mem_req = if_req | ls_req;
          if (w_if_win) begin
            mem_addr = if_addr;
            mem_be   = 4'hF;
          end else if (w_ls_win) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_be    = ls_be;
          end
          if_gnt = w_if_win & mem_gnt;
          ls_gnt = w_ls_win & mem_gnt;
        end
        S_IF_WAIT: begin
          busy      = 1'b1;
          if_rvalid = mem_rvalid;
          if_rdata  = mem_rvalid ? mem_rdata : 32'h0;
        end
        S_LS_WAIT: begin
          busy      = 1'b1;
          ls_rvalid = mem_rvalid;
          ls_rdata  = mem_rvalid ? mem_rdata : 32'h0;
        end
        default: busy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_starve_cnt <= '0;
      r_err        <= 1'b0;
    end else begin
      if (ls_gnt) begin
        if (!if_req)         r_starve_cnt <= '0;
        else if (!w_starved) r_starve_cnt <= r_starve_cnt + CW'(1);
      end else if (if_gnt) begin
        r_starve_cnt <= '0;
      end
      // A response with nothing outstanding is a protocol error; it stays flagged until reset.
      if (r_state == S_IDLE && mem_rvalid) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares whenever either rvalid is presented.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        busy, err;

  typedef struct packed {
    logic        is_ls;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  mem_port_arb #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every presented rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (if_rvalid || ls_rvalid) begin
      check("rvalid_exclusive", {31'h0, if_rvalid & ls_rvalid}, 32'h0);
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {31'h0, ls_rvalid}, 32'h2);
      end else begin
        resp_t r;
        r = exp_q.pop_front();
        check("resp_port_is_ls", {31'h0, ls_rvalid}, {31'h0, r.is_ls});
        check("resp_data", r.is_ls ? ls_rdata : if_rdata, r.data);
      end
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic respond(input logic is_ls, input logic [31:0] d);
    resp_t r;
    r.is_ls = is_ls;
    r.data  = d;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    exp_q.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    if_addr = 32'h0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_be = 4'h0;
    quiet();
    // Reset: outputs must stay quiet even with a request and grant present.
    if_req = 1'b1; mem_gnt = 1'b1;
    to_neg();
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    next_cyc();
    quiet();
    rst_n = 1'b0;
    to_neg();
    check("post_rst_err", {31'h0, err}, 32'h0);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    next_cyc();

    // Single fetch, response two cycles after grant.
    if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1;
    to_neg();
    check("t1_mem_req", {31'h0, mem_req}, 32'h1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_we", {31'h0, mem_we}, 32'h0);
    check("t1_mem_be", {28'h0, mem_be}, 32'hF);
    check("t1_if_gnt", {31'h0, if_gnt}, 32'h1);
    check("t1_ls_gnt", {31'h0, ls_gnt}, 32'h0);
    next_cyc();
    quiet();
    to_neg();
    check("t1_busy_c1", {31'h0, busy}, 32'h1);
    check("t1_mem_req_c1", {31'h0, mem_req}, 32'h0);
    next_cyc();
    respond(1'b0, 32'h0000_0013);
    to_neg();
    check("t1_busy_c2", {31'h0, busy}, 32'h1);
    check("t1_if_rvalid", {31'h0, if_rvalid}, 32'h1);
    next_cyc();
    quiet();
    to_neg();
    check("t1_busy_c3", {31'h0, busy}, 32'h0);
    next_cyc();

    // Store held through three refused cycles, then granted.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'h3;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      check("t2_mem_req_wait", {31'h0, mem_req}, 32'h1);
      check("t2_mem_addr_wait", mem_addr, 32'h2000);
      check("t2_ls_gnt_wait", {31'h0, ls_gnt}, 32'h0);
      next_cyc();
    end
    mem_gnt = 1'b1;
    to_neg();
    check("t2_ls_gnt", {31'h0, ls_gnt}, 32'h1);
    check("t2_mem_we", {31'h0, mem_we}, 32'h1);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t2_mem_be", {28'h0, mem_be}, 32'h3);
    next_cyc();
    // Response cycle: a new fetch request is ignored, then granted the very next cycle.
    quiet();
    if_req = 1'b1; if_addr = 32'h104; mem_gnt = 1'b1;
    respond(1'b1, 32'h0000_A5A5);
    to_neg();
    check("t2_wait_if_gnt", {31'h0, if_gnt}, 32'h0);
    check("t2_wait_mem_req", {31'h0, mem_req}, 32'h0);
    next_cyc();
    mem_rvalid = 1'b0;
    to_neg();
    check("t2_next_if_gnt", {31'h0, if_gnt}, 32'h1);
    check("t2_next_mem_addr", mem_addr, 32'h104);
    next_cyc();
    if_req = 1'b0;
    respond(1'b0, 32'h0000_0104);
    to_neg();
    next_cyc();
    quiet();

    // Both requesting: four store grants, then fetch forced through, then store again.
    if_req = 1'b1; if_addr = 32'h400;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000; ls_wdata = 32'h11; ls_be = 4'hF;
    mem_gnt = 1'b1;
    for (int g = 0; g < 6; g++) begin
      bit exp_if;
      exp_if = (g == 4);
      mem_rvalid = 1'b0;
      to_neg();
      check("t3_if_gnt", {31'h0, if_gnt}, {31'h0, exp_if});
      check("t3_ls_gnt", {31'h0, ls_gnt}, {31'h0, ~exp_if});
      check("t3_mem_addr", mem_addr, exp_if ? 32'h400 : 32'h2000);
      next_cyc();
      respond(~exp_if, 32'h3000 + 32'(g));
      to_neg();
      check("t3_wait_mem_req", {31'h0, mem_req}, 32'h0);
      next_cyc();
    end
    quiet();

    // Back-to-back fetches, one cycle grant-to-response.
    if_req = 1'b1; mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b0;
      if_addr = 32'h600 + 32'(4 * k);
      to_neg();
      check("t4_if_gnt", {31'h0, if_gnt}, 32'h1);
      check("t4_mem_addr", mem_addr, 32'h600 + 32'(4 * k));
      next_cyc();
      respond(1'b0, 32'h5000 + 32'(k));
      to_neg();
      check("t4_resp_if_gnt", {31'h0, if_gnt}, 32'h0);
      next_cyc();
    end
    quiet();

    // Reset in LS_WAIT abandons the store; fetch granted right after release.
    ls_req = 1'b1; mem_gnt = 1'b1;
    to_neg();
    check("t5_ls_gnt", {31'h0, ls_gnt}, 32'h1);
    next_cyc();
    quiet();
    rst_n = 1'b1;
    to_neg();
    check("t5_rst_busy", {31'h0, busy}, 32'h0);
    next_cyc();
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h700; mem_gnt = 1'b1;
    to_neg();
    check("t5_after_busy", {31'h0, busy}, 32'h0);
    check("t5_after_if_gnt", {31'h0, if_gnt}, 32'h1);
    check("t5_after_ls_rvalid", {31'h0, ls_rvalid}, 32'h0);
    next_cyc();
    quiet();
    respond(1'b0, 32'h0000_0700);
    to_neg();
    next_cyc();
    quiet();

    // Stray response while idle: no rvalid out, sticky err.
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    to_neg();
    check("t6_if_rdata", if_rdata, 32'h0);
    check("t6_ls_rdata", ls_rdata, 32'h0);
    next_cyc();
    quiet();
    for (int c = 0; c < 3; c++) begin
      to_neg();
      check("t6_err_sticky", {31'h0, err}, 32'h1);
      next_cyc();
    end
    rst_n = 1'b1;
    next_cyc();
    rst_n = 1'b0;
    to_neg();
    check("t6_err_cleared", {31'h0, err}, 32'h0);
    next_cyc();

    // Grant and stray response together in IDLE: grant taken, err set.
    if_req = 1'b1; if_addr = 32'h800; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    to_neg();
    check("t7_if_gnt", {31'h0, if_gnt}, 32'h1);
    next_cyc();
    quiet();
    to_neg();
    check("t7_err", {31'h0, err}, 32'h1);
    check("t7_busy", {31'h0, busy}, 32'h1);
    next_cyc();
    respond(1'b0, 32'h0000_0800);
    to_neg();
    next_cyc();
    quiet();
    to_neg();
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
